// File: rtl/ram_arbiter_pkg.sv
// Shared state/owner encodings, widths and the streak helper for the RAM arbiter.
package ram_arbiter_pkg;

  localparam int XLEN_WIDTH = 32;
  localparam int STREAK_W   = 4;
  localparam int WAIT_W     = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF  = 1'b0,
    ARB_OWN_MEM = 1'b1
  } arb_owner_e;

  // Saturating increment of the memory-grant streak, capped at the starvation limit.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur,
                                                      input logic [STREAK_W-1:0] limit);
    return (cur >= limit) ? limit : cur + 4'd1;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant picker: memory stage wins unless fetch has been starved long enough.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic                i_if_req,
  input  logic                i_mem_req,
  input  logic [STREAK_W-1:0] i_streak,
  input  logic [STREAK_W-1:0] i_starve_limit,
  output logic                o_grant_valid,
  output logic                o_grant_owner
);

  // Fetch only wins when it is alone or when the memory streak has hit the limit.
  always_comb begin
    o_grant_valid = i_if_req | i_mem_req;
    o_grant_owner = ARB_OWN_MEM;
    if (i_if_req && (!i_mem_req || (i_streak == i_starve_limit))) begin
      o_grant_owner = ARB_OWN_IF;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the fetch and memory stages: arbitrate,
// issue one registered access, wait out the read latency, then pulse ready.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [XLEN_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [XLEN_WIDTH-1:0] if_data,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [XLEN_WIDTH-1:0] mem_addr,
  input  logic [XLEN_WIDTH-1:0] mem_wdata,
  output logic                  mem_ready,
  output logic [XLEN_WIDTH-1:0] mem_rdata,
  output logic                  ram_en,
  output logic                  ram_write_en,
  output logic [XLEN_WIDTH-1:0] ram_addr,
  output logic [XLEN_WIDTH-1:0] ram_write_data,
  input  logic [XLEN_WIDTH-1:0] ram_read_data,
  output logic                  pause_signal
);

  localparam logic [STREAK_W-1:0] LIMIT     = STREAK_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]   WAIT_LOAD = WAIT_W'(RD_LATENCY - 1);

  arb_state_e            r_state;
  arb_owner_e            r_owner;
  logic                  r_we;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_ram_en;
  logic                  r_ram_write_en;
  logic [XLEN_WIDTH-1:0] r_ram_addr;
  logic [XLEN_WIDTH-1:0] r_ram_write_data;
  logic                  r_if_ready;
  logic                  r_mem_ready;
  logic [XLEN_WIDTH-1:0] r_if_data;
  logic [XLEN_WIDTH-1:0] r_mem_rdata;

  logic                  w_grant_valid;
  logic                  w_grant_owner;
  logic [XLEN_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_we;
  logic [XLEN_WIDTH-1:0] w_sel_wdata;

  ram_arb_pick u_pick (
    .i_if_req       (if_req),
    .i_mem_req      (mem_req),
    .i_streak       (r_streak),
    .i_starve_limit (LIMIT),
    .o_grant_valid  (w_grant_valid),
    .o_grant_owner  (w_grant_owner)
  );

  // Select the winning request's address/we/data; fetch can never write.
  always_comb begin
    w_sel_addr  = mem_addr;
    w_sel_we    = mem_we;
    w_sel_wdata = mem_we ? mem_wdata : '0;
    if (w_grant_owner == ARB_OWN_IF) begin
      w_sel_addr  = if_addr;
      w_sel_we    = 1'b0;
      w_sel_wdata = '0;
    end
  end

  // Arbiter FSM: RAM strobes and ready pulses default low and are set for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ARB_IDLE;
      r_owner          <= ARB_OWN_IF;
      r_we             <= 1'b0;
      r_wait_cnt       <= '0;
      r_streak         <= '0;
      r_ram_en         <= 1'b0;
      r_ram_write_en   <= 1'b0;
      r_ram_addr       <= '0;
      r_ram_write_data <= '0;
      r_if_ready       <= 1'b0;
      r_mem_ready      <= 1'b0;
      r_if_data        <= '0;
      r_mem_rdata      <= '0;
    end else begin
      r_ram_en         <= 1'b0;
      r_ram_write_en   <= 1'b0;
      r_ram_addr       <= '0;
      r_ram_write_data <= '0;
      r_if_ready       <= 1'b0;
      r_mem_ready      <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            r_owner          <= arb_owner_e'(w_grant_owner);
            r_we             <= w_sel_we;
            r_ram_en         <= 1'b1;
            r_ram_write_en   <= w_sel_we;
            r_ram_addr       <= w_sel_addr;
            r_ram_write_data <= w_sel_wdata;
            if ((w_grant_owner == ARB_OWN_IF) || !if_req) begin
              r_streak <= '0;
            end else begin
              r_streak <= streak_inc(r_streak, LIMIT);
            end
            r_state <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (r_we) begin
            r_mem_ready <= 1'b1;
            r_state     <= ARB_RESP;
          end else begin
            r_wait_cnt <= WAIT_LOAD;
            r_state    <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (r_wait_cnt != 2'd0) begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end else begin
            if (r_owner == ARB_OWN_IF) begin
              r_if_data  <= ram_read_data;
              r_if_ready <= 1'b1;
            end else begin
              r_mem_rdata <= ram_read_data;
              r_mem_ready <= 1'b1;
            end
            r_state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign ram_en         = r_ram_en;
  assign ram_write_en   = r_ram_write_en;
  assign ram_addr       = r_ram_addr;
  assign ram_write_data = r_ram_write_data;
  assign if_ready       = r_if_ready;
  assign mem_ready      = r_mem_ready;
  assign if_data        = r_if_data;
  assign mem_rdata      = r_mem_rdata;
  assign pause_signal   = (mem_req & ~r_mem_ready) | (if_req & ~r_if_ready);

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data/instruction RAM between the fetch stage and the memory stage.
- Accepts level-held requests from both stages and arbitrates between them, memory stage first, with a starvation guard for fetch.
- Sequences the RAM access with a configurable read latency, returns data with a one-cycle ready pulse, and raises pause to pipeline control while either requester is waiting.
- Sits between the memory stage / fetch stage and the RAM.

Parameters:
- RD_LATENCY, 1, cycles from the RAM sampling a read address to ram_read_data being valid; legal range 1..4.
- STARVE_LIMIT, 4, consecutive memory-stage grants taken while if_req is pending before fetch is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  XLEN_WIDTH  fetch address
- if_ready  out  1  one-cycle pulse; if_data valid
- if_data  out  XLEN_WIDTH  fetched word, held until next if_ready
- mem_req  in  1  memory-stage request, held until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  XLEN_WIDTH  load/store address
- mem_wdata  in  XLEN_WIDTH  store data
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  XLEN_WIDTH  load data, held until next load completes
- ram_en  out  1  RAM access strobe
- ram_write_en  out  1  RAM write enable
- ram_addr  out  XLEN_WIDTH  RAM address
- ram_write_data  out  XLEN_WIDTH  RAM write data
- ram_read_data  in  XLEN_WIDTH  RAM read data
- pause_signal  out  1  stall request to pipeline control

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state = IDLE; streak = 0; wait counter = 0. All outputs are 0: ram_en, ram_write_en, ram_addr, ram_write_data, if_ready, mem_ready, if_data, mem_rdata, pause_signal.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant that requester.
- IDLE, both requests: grant fetch if streak == STARVE_LIMIT, otherwise grant memory.
- On grant:
  - latch the owner, address, we (forced to 0 for fetch) and wdata;
  - go to ISSUE.
- ISSUE: registered outputs drive the latched request for exactly one cycle.
  - ram_en = 1, ram_addr = latched address.
  - ram_write_en = latched we.
  - ram_write_data = latched wdata for a store, otherwise 0.
  - Write: next state RESP.
  - Read: next state WAIT, counter loaded with RD_LATENCY-1.
- WAIT: all RAM outputs are 0.
  - Counter > 0: decrement and stay.
  - Counter == 0 (RD_LATENCY cycles after ISSUE): capture ram_read_data into the owner's data register and go to RESP.
- RESP: the owner's ready pulses for one cycle; no arbitration this cycle; next state IDLE.
- Latency (request seen in IDLE at cycle 0):
  - read: ready in cycle 2+RD_LATENCY;
  - store: mem_ready in cycle 2;
  - minimum spacing between grants is 4 cycles for a read and 3 for a store (RD_LATENCY = 1).
- Requester rule: drop req, or present the next request, in the cycle after ready. Address and data are latched at grant, so changes after grant are ignored.
- Streak counter:
  - increments on a memory grant while if_req = 1, saturating at STARVE_LIMIT;
  - clears on any fetch grant;
  - clears on a memory grant while if_req = 0.
- pause_signal = (mem_req & ~mem_ready) | (if_req & ~if_ready). It is combinational from registered state, and 0 in the ready cycle of the owner.
- Data registers update only at capture. if_data and mem_rdata keep their values otherwise.
- rst during ISSUE, WAIT or RESP: the in-flight access is abandoned, all outputs clear the next cycle, and no ready is issued.
- mem_we = 1 with a fetch: impossible, because fetch grants force we = 0.

Decomposition:
- New include define/arb.v:
  - state encodings ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP (2 bits);
  - owner encodings ARB_OWN_IF, ARB_OWN_MEM.
- Reuse XLEN_WIDTH, true and false from define/const.v.
- One combinational sub-module, ram_arb_pick. Inputs: if_req, mem_req, streak, STARVE_LIMIT. Outputs: grant_valid, grant_owner. The FSM, counters and registers stay in ram_arbiter.

Test Plan:
- Reset, then if_req = 1, if_addr = 0x100, RAM returns 0x00000013 (RD_LATENCY = 1) -> ram_en only in cycle 1 with ram_addr 0x100; if_ready pulses in cycle 3 with if_data = 0x13; pause_signal 1 in cycles 0-2.
- mem_req = 1, mem_we = 1, addr 0x2000, wdata 0xDEADBEEF -> ram_write_en = 1 in cycle 1 with those values; mem_ready in cycle 2; mem_rdata unchanged.
- if_req and mem_req both held continuously with STARVE_LIMIT = 4 -> grant order mem, mem, mem, mem, if, mem... Fetch completes exactly once per 5 grants.
- RD_LATENCY = 3: load at 0x40, RAM data 0xCAFE0001 valid in cycle 4 -> mem_ready in cycle 5 with mem_rdata = 0xCAFE0001; ram_en 0 in cycles 2-5.
- rst asserted in the WAIT cycle of a fetch -> next cycle state IDLE and all outputs 0; no if_ready ever pulses for the abandoned fetch. After rst drops with if_req still 1, the fetch is re-granted.
- Requester holds mem_req through the RESP cycle and the following cycle -> a second memory grant is issued in the cycle after RESP (back-to-back requests accepted); the RESP cycle itself issues no grant.
